// File: rtl/tcu_pkg.sv
// Shared mode type and conversion helpers for the multi-zone temperature control unit.
package tcu_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_COOL = 2'b01,
    MODE_HEAT = 2'b10
  } tcu_mode_e;

  localparam int TEMP_W = 8;

  // Raw sensor word carries signed integer degrees C in bits [11:4].
  function automatic logic signed [TEMP_W-1:0] raw_to_c(input logic [31:0] raw);
    return raw[11:4];
  endfunction

  function automatic int dac_scale(input int err, input int gain, input int max_code);
    int mag;
    int prod;
    mag  = (err < 0) ? -err : err;
    prod = mag * gain;
    return (prod > max_code) ? max_code : prod;
  endfunction

endpackage

// File: rtl/tcu_avg_filter.sv
// Per-zone moving-average filter: ring buffer of the last 2^AVG_LOG2 samples plus a running sum.
// The first sample after reset pre-fills the whole history of its zone.
module tcu_avg_filter
  import tcu_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int AVG_LOG2  = 2,
  parameter int ZW        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ZW-1:0]            in_zone,
  input  logic signed [TEMP_W-1:0] in_temp,
  output logic signed [TEMP_W-1:0] tf
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;

  logic signed [TEMP_W-1:0] hist_reg [NUM_ZONES][DEPTH];
  logic [AVG_LOG2-1:0]      ptr_reg  [NUM_ZONES];
  logic signed [SUM_W-1:0]  sum_reg  [NUM_ZONES];
  logic [NUM_ZONES-1:0]     filled_reg;

  logic signed [SUM_W-1:0]  temp_ext;
  logic signed [SUM_W-1:0]  oldest_ext;
  logic signed [SUM_W-1:0]  sum_next;

  // Combinational read so a back-to-back sample to the same zone sees the previous update.
  always_comb begin
    temp_ext   = SUM_W'(in_temp);
    oldest_ext = SUM_W'(hist_reg[in_zone][ptr_reg[in_zone]]);
    if (filled_reg[in_zone]) begin
      sum_next = sum_reg[in_zone] - oldest_ext + temp_ext;
    end else begin
      sum_next = temp_ext <<< AVG_LOG2;
    end
    tf = TEMP_W'(sum_next >>> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filled_reg <= '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        ptr_reg[i] <= '0;
        sum_reg[i] <= '0;
      end
    end else if (in_valid) begin
      filled_reg[in_zone] <= 1'b1;
      sum_reg[in_zone]    <= sum_next;
      ptr_reg[in_zone]    <= ptr_reg[in_zone] + AVG_LOG2'(1);
      for (int d = 0; d < DEPTH; d++) begin
        if (!filled_reg[in_zone] || d == int'(ptr_reg[in_zone])) begin
          hist_reg[in_zone][d] <= in_temp;
        end
      end
    end
  end

endmodule

// File: rtl/multi_zone_tcu.sv
// Multi-zone temperature control unit: per-zone hysteresis FSM driving a saturating DAC code,
// two-stage result pipeline. Define TCU_AVG_FILTER_EN to insert the moving-average filter.
module multi_zone_tcu
  import tcu_pkg::*;
#(
  parameter int  NUM_ZONES    = 4,
  parameter int  SENSOR_WIDTH = 16,
  parameter int  DAC_WIDTH    = 8,
  parameter int  HYST         = 1,
  parameter int  GAIN         = 8,
  parameter int  AVG_LOG2     = 2,
  parameter int  DEFAULT_SP   = 25,
  localparam int ZW           = $clog2(NUM_ZONES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sensor_data_valid,
  input  logic [ZW-1:0]           sensor_zone,
  input  logic [SENSOR_WIDTH-1:0] sensor_out,
  input  logic                    sp_wr_en,
  input  logic [ZW-1:0]           sp_wr_zone,
  input  logic [7:0]              sp_wr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ZW-1:0]           out_zone,
  output logic [1:0]              out_mode,
  output logic [DAC_WIDTH-1:0]    out_dac,
  output logic [NUM_ZONES-1:0]    on_off,
  output logic                    drop_pulse
);

  localparam int DAC_MAX = (1 << DAC_WIDTH) - 1;

  logic                     accept;
  logic signed [TEMP_W-1:0] t_raw;
  logic signed [TEMP_W-1:0] tf_next;

  assign accept = sensor_data_valid && (int'(sensor_zone) < NUM_ZONES);
  assign t_raw  = raw_to_c(32'(sensor_out));

`ifdef TCU_AVG_FILTER_EN
  tcu_avg_filter #(
    .NUM_ZONES (NUM_ZONES),
    .AVG_LOG2  (AVG_LOG2),
    .ZW        (ZW)
  ) u_avg_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_zone  (sensor_zone),
    .in_temp  (t_raw),
    .tf       (tf_next)
  );
`else
  assign tf_next = t_raw;
`endif

  logic signed [TEMP_W-1:0] sp_reg [NUM_ZONES];
  logic                     s1_valid_reg;
  logic [ZW-1:0]            s1_zone_reg;
  logic signed [TEMP_W-1:0] s1_tf_reg;
  logic signed [TEMP_W-1:0] s1_sp_reg;

  // The setpoint is captured with the sample, so a same-cycle write only affects later samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_zone_reg  <= '0;
      s1_tf_reg    <= '0;
      s1_sp_reg    <= '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        sp_reg[i] <= TEMP_W'(DEFAULT_SP);
      end
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_zone_reg <= sensor_zone;
        s1_tf_reg   <= tf_next;
        s1_sp_reg   <= sp_reg[sensor_zone];
      end
      if (sp_wr_en && int'(sp_wr_zone) < NUM_ZONES) begin
        sp_reg[sp_wr_zone] <= sp_wr_data;
      end
    end
  end

  tcu_mode_e state_reg [NUM_ZONES];
  tcu_mode_e cur_mode;
  tcu_mode_e next_mode;
  int        tf_i;
  int        sp_i;
  int        dac_i;

  always_comb begin
    cur_mode  = state_reg[s1_zone_reg];
    tf_i      = int'(s1_tf_reg);
    sp_i      = int'(s1_sp_reg);
    next_mode = cur_mode;
    case (cur_mode)
      MODE_OFF: begin
        if (tf_i > sp_i + HYST) begin
          next_mode = MODE_COOL;
        end else if (tf_i < sp_i - HYST) begin
          next_mode = MODE_HEAT;
        end
      end
      MODE_COOL: if (tf_i <= sp_i) next_mode = MODE_OFF;
      MODE_HEAT: if (tf_i >= sp_i) next_mode = MODE_OFF;
      default:   next_mode = MODE_OFF;
    endcase
    dac_i = (next_mode == MODE_OFF) ? 0 : dac_scale(tf_i - sp_i, GAIN, DAC_MAX);
  end

  // A new result always wins the output register; an unconsumed one is reported as dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_zone   <= '0;
      out_mode   <= '0;
      out_dac    <= '0;
      drop_pulse <= 1'b0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        state_reg[i] <= MODE_OFF;
      end
    end else begin
      drop_pulse <= 1'b0;
      if (s1_valid_reg) begin
        state_reg[s1_zone_reg] <= next_mode;
        out_valid  <= 1'b1;
        out_zone   <= s1_zone_reg;
        out_mode   <= next_mode;
        out_dac    <= DAC_WIDTH'(dac_i);
        drop_pulse <= out_valid && !out_ready;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_on_off
    assign on_off[gi] = (state_reg[gi] != MODE_OFF);
  end

endmodule

// File: tb/tb_multi_zone_tcu.sv
// Bench for multi_zone_tcu: directed scenarios plus a randomized run, all checked every cycle
// against a sample-ordered behavioural model; honours TCU_AVG_FILTER_EN like the design.
`timescale 1ns/1ps
module tb_multi_zone_tcu;

  localparam int NZ       = 4;
  localparam int ZW       = 2;
  localparam int DW       = 8;
  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int HYST     = 1;
  localparam int GAIN     = 8;
  localparam int DEF_SP   = 25;
  localparam int DAC_MAX  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sensor_data_valid;
  logic [ZW-1:0] sensor_zone;
  logic [15:0]   sensor_out;
  logic          sp_wr_en;
  logic [ZW-1:0] sp_wr_zone;
  logic [7:0]    sp_wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] out_zone;
  logic [1:0]    out_mode;
  logic [DW-1:0] out_dac;
  logic [NZ-1:0] on_off;
  logic          drop_pulse;

  multi_zone_tcu #(
    .NUM_ZONES    (NZ),
    .SENSOR_WIDTH (16),
    .DAC_WIDTH    (DW),
    .HYST         (HYST),
    .GAIN         (GAIN),
    .AVG_LOG2     (AVG_LOG2),
    .DEFAULT_SP   (DEF_SP)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sensor_data_valid (sensor_data_valid),
    .sensor_zone       (sensor_zone),
    .sensor_out        (sensor_out),
    .sp_wr_en          (sp_wr_en),
    .sp_wr_zone        (sp_wr_zone),
    .sp_wr_data        (sp_wr_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_zone          (out_zone),
    .out_mode          (out_mode),
    .out_dac           (out_dac),
    .on_off            (on_off),
    .drop_pulse        (drop_pulse)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: modes 0=OFF 1=COOL 2=HEAT, samples handled in arrival order.
  int st [NZ];
  int sp [NZ];
  int hq [NZ][$];
  bit e_valid, e_drop, e_landed;
  int e_zone, e_mode, e_dac, e_onoff;
  bit p_valid;
  int p_zone, p_mode, p_dac, p_onoff;

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) begin
      st[i] = 0;
      sp[i] = DEF_SP;
      hq[i].delete();
    end
    e_valid = 0; e_drop = 0; e_landed = 0;
    e_zone = 0; e_mode = 0; e_dac = 0; e_onoff = 0;
    p_valid = 0;
  endtask

  task automatic filt(input int z, input int t, output int tf);
`ifdef TCU_AVG_FILTER_EN
    int s;
    int q;
    if (hq[z].size() == 0) begin
      for (int i = 0; i < DEPTH; i++) hq[z].push_back(t);
    end else begin
      void'(hq[z].pop_front());
      hq[z].push_back(t);
    end
    s = 0;
    for (int i = 0; i < hq[z].size(); i++) s += hq[z][i];
    q = s / DEPTH;
    if (s < 0 && q * DEPTH != s) q--;
    tf = q;
`else
    tf = t + 0 * z;
`endif
  endtask

  task automatic model_edge(input bit v, input int z, input int t, input bit we,
                            input int wz, input int wd, input bit rdy);
    int tf, n, err, d;
    e_drop   = 0;
    e_landed = 0;
    if (p_valid) begin
      if (e_valid && !rdy) e_drop = 1;
      e_valid = 1; e_landed = 1;
      e_zone = p_zone; e_mode = p_mode; e_dac = p_dac; e_onoff = p_onoff;
    end else if (rdy) begin
      e_valid = 0;
    end
    p_valid = 0;
    if (v && z < NZ) begin
      filt(z, t, tf);
      case (st[z])
        0:       n = (tf > sp[z] + HYST) ? 1 : (tf < sp[z] - HYST) ? 2 : 0;
        1:       n = (tf <= sp[z]) ? 0 : 1;
        default: n = (tf >= sp[z]) ? 0 : 2;
      endcase
      err = (tf > sp[z]) ? tf - sp[z] : sp[z] - tf;
      d = err * GAIN;
      if (d > DAC_MAX) d = DAC_MAX;
      st[z]   = n;
      p_valid = 1; p_zone = z; p_mode = n; p_dac = (n == 0) ? 0 : d;
      p_onoff = 0;
      for (int i = 0; i < NZ; i++) if (st[i] != 0) p_onoff |= (1 << i);
    end
    if (we && wz < NZ) sp[wz] = (wd > 127) ? wd - 256 : wd;
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("out_zone", out_zone, e_zone);
      chk("out_mode", out_mode, e_mode);
      chk("out_dac", out_dac, e_dac);
    end
    chk("on_off", on_off, e_onoff);
    chk("drop_pulse", drop_pulse, e_drop);
    if (e_landed)
      $display("[TB] result zone=%0d mode=%0d dac=%0d drop=%0d", e_zone, e_mode, e_dac, e_drop);
  endtask

  task automatic step(input bit v, input int z, input int t, input bit we,
                      input int wz, input int wd, input bit rdy);
    logic [7:0] t8;
    t8 = 8'(t);
    sensor_data_valid = v;
    sensor_zone       = ZW'(z);
    sensor_out        = {4'($urandom), t8, 4'($urandom)};
    sp_wr_en          = we;
    sp_wr_zone        = ZW'(wz);
    sp_wr_data        = 8'(wd);
    out_ready         = rdy;
    @(posedge clk);
    model_edge(v, z, t, we, wz, wd, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic sample(input int z, input int t, input bit rdy = 1'b1);
    step(1'b1, z, t, 1'b0, 0, 0, rdy);
  endtask

  task automatic idle(input bit rdy = 1'b1);
    step(1'b0, 0, 0, 1'b0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sensor_data_valid = 1'b0;
    sp_wr_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sensor_data_valid = 1'b0; sensor_zone = '0; sensor_out = '0;
    sp_wr_en = 1'b0; sp_wr_zone = '0; sp_wr_data = '0; out_ready = 1'b1;

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_on_off", on_off, 0);
    chk("rst_out_dac", out_dac, 0);
    sample(0, 30); idle();
    chk("cool30_zone", out_zone, 0);
    chk("cool30_mode", out_mode, 1);
    chk("cool30_dac", out_dac, 40);
    chk("cool30_on_off0", on_off[0], 1);

    // Sample in flight when reset arrives must never appear.
    sample(0, 30);
    do_reset();
    idle(); idle();
    chk("flush_valid", out_valid, 0);

    do_reset();
    sample(1, 26); idle();
    chk("hy26_mode", out_mode, 0);
    chk("hy26_dac", out_dac, 0);
    sample(1, 24); idle();
    chk("hy24_mode", out_mode, 0);
    sample(1, 23); idle();
`ifndef TCU_AVG_FILTER_EN
    chk("hy23_mode", out_mode, 2);
    chk("hy23_dac", out_dac, 16);
`endif

    do_reset();
    sample(0, 30); idle();
    sample(0, 25); idle();
`ifndef TCU_AVG_FILTER_EN
    chk("bnd25_mode", out_mode, 0);
`endif
    sample(0, 27); idle();
`ifndef TCU_AVG_FILTER_EN
    chk("bnd27_mode", out_mode, 1);
`endif

    do_reset();
    step(1'b0, 0, 0, 1'b1, 3, 20, 1'b1);
    sample(3, 20); sample(3, 20); sample(3, 20); sample(3, 40); idle();
    chk("avg_mode", out_mode, 1);
`ifdef TCU_AVG_FILTER_EN
    chk("avg_dac", out_dac, 40);
`else
    chk("avg_dac", out_dac, 160);
`endif

    do_reset();
    sample(3, 85, 1'b0);
    sample(1, 30, 1'b0);
    chk("sat_dac", out_dac, 255);
    chk("sat_zone", out_zone, 3);
    idle(1'b0);
    chk("drop_hit", drop_pulse, 1);
    chk("drop_zone", out_zone, 1);
    chk("drop_dac", out_dac, 40);
    idle(1'b0);
    chk("drop_clear", drop_pulse, 0);
    chk("drop_hold_valid", out_valid, 1);
    idle(1'b1);

    do_reset();
    step(1'b1, 2, 28, 1'b1, 2, 30, 1'b1); idle();
    chk("spw_old_mode", out_mode, 1);
    chk("spw_old_dac", out_dac, 24);
    sample(2, 28); idle();
    chk("spw_new_mode", out_mode, 0);
    chk("spw_new_dac", out_dac, 0);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit v, we, rdy;
      int z, t, wz, wd;
      v   = ($urandom_range(0, 9) < 7);
      z   = int'($urandom_range(0, NZ - 1));
      t   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) - 128
                                        : int'($urandom_range(10, 42));
      we  = ($urandom_range(0, 9) == 0);
      wz  = int'($urandom_range(0, NZ - 1));
      wd  = int'($urandom_range(15, 35));
      rdy = ($urandom_range(0, 9) < 7);
      step(v, z, t, we, wz, wd, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
